dma_ctrl: RTL

- Single-channel word-copy DMA engine; the next block to hang off the 2-master/4-slave BUS.
- Its slave port is configured by the CPU-side master through one bus slave slot (decoded 16-word window).
- Its master port is wired to the bus's second master port and copies SIZE words from SRC to DST using bus read/write cycles.
- Sets a done flag and irq on completion.

---
 rtl/dma_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel word-copy DMA engine.
//   Slave port (S_*): 16-word register window programmed by the CPU-side master.
//     0x0 SRC, 0x1 DST, 0x2 SIZE, 0x3 CTRL (wo: b0 START, b1 CLR_DONE),
//     0x4 STATUS (ro: b0 BUSY, b1 DONE, [15:8] remaining count). Reads are
//     registered: S_dout updates one edge after a read select.
//   Master port (M_*): copies SIZE words SRC->DST, three cycles per word once
//     granted. M_req is held from REQ through the last WRITE so the arbiter
//     keeps the bus locked for the whole job.
//   irq: level interrupt, mirrors DONE.
module dma_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  S_sel,
  input  logic                  S_wr,
  input  logic [ADDR_WIDTH-1:0] S_address,
  input  logic [DATA_WIDTH-1:0] S_din,
  output logic [DATA_WIDTH-1:0] S_dout,
  output logic                  M_req,
  output logic                  M_wr,
  output logic [ADDR_WIDTH-1:0] M_address,
  output logic [DATA_WIDTH-1:0] M_dout,
  input  logic                  M_grant,
  input  logic [DATA_WIDTH-1:0] M_din,
  output logic                  irq
);

  typedef enum logic [2:0] {IDLE, REQ, READ, CAPTURE, WRITE, FINISH} state_t;

  localparam logic [3:0] OFF_SRC    = 4'h0;
  localparam logic [3:0] OFF_DST    = 4'h1;
  localparam logic [3:0] OFF_SIZE   = 4'h2;
  localparam logic [3:0] OFF_CTRL   = 4'h3;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_reg, dst_reg, src_ptr, dst_ptr, addr_hold;
  logic [CNT_WIDTH-1:0]  size_reg, count;
  logic [DATA_WIDTH-1:0] buffer, dout_hold, rdata;
  logic                  done;

  logic [3:0] offs;
  logic       wr_en, rd_en, busy, start, clr_done, xfer;

  // Only the low nibble of the address and the low data bits are decoded.
  logic unused_bits;
  assign unused_bits = ^{S_address[ADDR_WIDTH-1:4], S_din};

  assign offs     = S_address[3:0];
  assign wr_en    = S_sel & S_wr;
  assign rd_en    = S_sel & ~S_wr;
  assign busy     = (state != IDLE);
  assign start    = wr_en && (offs == OFF_CTRL) && S_din[0] && !busy;
  assign clr_done = wr_en && (offs == OFF_CTRL) && S_din[1];
  assign xfer     = (state == WRITE) && M_grant;
  assign irq      = done;

  always_comb begin
    rdata = '0;
    case (offs)
      OFF_SRC:  rdata[ADDR_WIDTH-1:0] = src_reg;
      OFF_DST:  rdata[ADDR_WIDTH-1:0] = dst_reg;
      OFF_SIZE: rdata[CNT_WIDTH-1:0]  = size_reg;
      OFF_STATUS: begin
        rdata[0]            = busy;
        rdata[1]            = done;
        rdata[8 +: CNT_WIDTH] = count;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Address/data are driven only in READ/WRITE; every other state replays the
  // last driven value so the bus sees stable lines when the engine is idle.
  always_comb begin
    state_nxt = state;
    M_req     = 1'b0;
    M_wr      = 1'b0;
    M_address = addr_hold;
    M_dout    = dout_hold;
    case (state)
      IDLE:    if (start && size_reg != '0) state_nxt = REQ;
      REQ: begin
        M_req = 1'b1;
        if (M_grant) state_nxt = READ;
      end
      READ: begin
        M_req     = 1'b1;
        M_address = src_ptr;
        if (M_grant) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        M_req     = 1'b1;
        // Losing the grant here means the read data is not trustworthy: reissue.
        state_nxt = M_grant ? WRITE : READ;
      end
      WRITE: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = dst_ptr;
        M_dout    = buffer;
        if (M_grant) state_nxt = (count != CNT_WIDTH'(1)) ? READ : FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      size_reg  <= '0;
      count     <= '0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      buffer    <= '0;
      addr_hold <= '0;
      dout_hold <= '0;
      done      <= 1'b0;
      S_dout    <= '0;
    end else begin
      addr_hold <= M_address;
      dout_hold <= M_dout;

      // Config is frozen while busy. Writing SIZE also loads the remaining
      // count so STATUS reflects the programmed length before START.
      if (wr_en && !busy) begin
        case (offs)
          OFF_SRC:  src_reg <= S_din[ADDR_WIDTH-1:0];
          OFF_DST:  dst_reg <= S_din[ADDR_WIDTH-1:0];
          OFF_SIZE: begin
            size_reg <= S_din[CNT_WIDTH-1:0];
            count    <= S_din[CNT_WIDTH-1:0];
          end
          default: ;
        endcase
      end

      // START outranks CLR_DONE in the same write.
      if (start) begin
        if (size_reg == '0) begin
          done <= 1'b1;
        end else begin
          src_ptr <= src_reg;
          dst_ptr <= dst_reg;
          count   <= size_reg;
          done    <= 1'b0;
        end
      end else if (clr_done) begin
        done <= 1'b0;
      end

      if (state == CAPTURE && M_grant) buffer <= M_din;

      if (xfer) begin
        src_ptr <= src_ptr + 1'b1;
        dst_ptr <= dst_ptr + 1'b1;
        count   <= count - 1'b1;
      end

      if (state == FINISH) done <= 1'b1;

      if (rd_en) S_dout <= rdata;
    end
  end

endmodule
